// File: rtl/seg7_pkg.sv
// Shared glyph definitions for the multiplexed seven-segment driver.
// Glyphs are active-high {g,f,e,d,c,b,a}; output polarity is applied at the pins.
package seg7_pkg;

    localparam logic [6:0] GLYPH_0    = 7'h3F;
    localparam logic [6:0] GLYPH_1    = 7'h06;
    localparam logic [6:0] GLYPH_2    = 7'h5B;
    localparam logic [6:0] GLYPH_3    = 7'h4F;
    localparam logic [6:0] GLYPH_4    = 7'h66;
    localparam logic [6:0] GLYPH_5    = 7'h6D;
    localparam logic [6:0] GLYPH_6    = 7'h7D;
    localparam logic [6:0] GLYPH_7    = 7'h07;
    localparam logic [6:0] GLYPH_8    = 7'h7F;
    localparam logic [6:0] GLYPH_9    = 7'h6F;
    localparam logic [6:0] GLYPH_A    = 7'h77;
    localparam logic [6:0] GLYPH_B    = 7'h7C;
    localparam logic [6:0] GLYPH_C    = 7'h39;
    localparam logic [6:0] GLYPH_D    = 7'h5E;
    localparam logic [6:0] GLYPH_E    = 7'h79;
    localparam logic [6:0] GLYPH_F    = 7'h71;
    localparam logic [6:0] GLYPH_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF    = 7'h00;

    function automatic logic [6:0] nibble_to_glyph(input logic [3:0] nib);
        case (nib)
            4'h0:    return GLYPH_0;
            4'h1:    return GLYPH_1;
            4'h2:    return GLYPH_2;
            4'h3:    return GLYPH_3;
            4'h4:    return GLYPH_4;
            4'h5:    return GLYPH_5;
            4'h6:    return GLYPH_6;
            4'h7:    return GLYPH_7;
            4'h8:    return GLYPH_8;
            4'h9:    return GLYPH_9;
            4'hA:    return GLYPH_A;
            4'hB:    return GLYPH_B;
            4'hC:    return GLYPH_C;
            4'hD:    return GLYPH_D;
            4'hE:    return GLYPH_E;
            default: return GLYPH_F;
        endcase
    endfunction

endpackage

// File: rtl/seg7_scan_display_bin2bcd_iter.sv
// Iterative double-dabble converter, one bit per clock; hex mode passes nibbles through.
// done_o marks the final busy cycle, when bcd_o/overflow_o carry the finished result.
module bin2bcd_iter
    import seg7_pkg::*;
#(
    parameter int BIN_WIDTH  = 14,
    parameter int NUM_DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start_i,
    input  logic                      hex_i,
    input  logic [BIN_WIDTH-1:0]      value_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [4*NUM_DIGITS-1:0]   bcd_o,
    output logic                      overflow_o
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(BIN_WIDTH + 1);
    localparam int EXT_W = (BIN_WIDTH > BCD_W) ? BIN_WIDTH : BCD_W;

    logic                 busy_q, busy_d;
    logic                 hex_q, hex_d;
    logic [BIN_WIDTH-1:0] shift_q, shift_d;
    logic [BCD_W-1:0]     bcd_q, bcd_d;
    logic                 ovf_q, ovf_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic [BCD_W-1:0] adj;
    logic [BCD_W-1:0] dd_next;
    logic             dd_ovf;
    logic             last;
    logic [EXT_W-1:0] value_ext;

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
        assign adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ? bcd_q[gi*4 +: 4] + 4'd3
                                                           : bcd_q[gi*4 +: 4];
    end

    // A 1 leaving the top nibble means the value needs more digits than we have.
    assign dd_next   = {adj[BCD_W-2:0], shift_q[BIN_WIDTH-1]};
    assign dd_ovf    = ovf_q | adj[BCD_W-1];
    assign last      = (cnt_q == CNT_W'(BIN_WIDTH - 1));
    assign value_ext = EXT_W'(shift_q);

    always_comb begin
        busy_d  = busy_q;
        hex_d   = hex_q;
        shift_d = shift_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        if (busy_q) begin
            if (hex_q) begin
                busy_d = 1'b0;
            end else begin
                bcd_d   = dd_next;
                ovf_d   = dd_ovf;
                shift_d = shift_q << 1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (last) busy_d = 1'b0;
            end
        end else if (start_i) begin
            busy_d  = 1'b1;
            hex_d   = hex_i;
            shift_d = value_i;
            bcd_d   = '0;
            ovf_d   = 1'b0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q  <= 1'b0;
            hex_q   <= 1'b0;
            shift_q <= '0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            busy_q  <= busy_d;
            hex_q   <= hex_d;
            shift_q <= shift_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = busy_q & (hex_q | last);
    assign bcd_o      = hex_q ? value_ext[BCD_W-1:0] : dd_next;
    assign overflow_o = hex_q ? |(value_ext >> BCD_W) : dd_ovf;

endmodule

// File: rtl/seg7_scan_display.sv
// Multi-digit scanned seven-segment driver: converts a binary value, holds the
// committed digits and time-multiplexes them onto one shared segment bus.
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int BIN_WIDTH   = 14,
    parameter int REFRESH_DIV = 50000,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [BIN_WIDTH-1:0]  value,
    input  logic                  load,
    input  logic                  hex_mode,
    input  logic                  blank_lz,
    input  logic [NUM_DIGITS-1:0] dp_mask,
    output logic                  busy,
    output logic                  overflow,
    output logic [NUM_DIGITS-1:0] digit_sel,
    output logic [6:0]            seg,
    output logic                  dp
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRE_W = $clog2(REFRESH_DIV);
    localparam logic [6:0]            SEG_IDLE = ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
    localparam logic [NUM_DIGITS-1:0] SEL_IDLE = ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : '0;

    logic [BCD_W-1:0]      digits_q, digits_d;
    logic                  ovf_q, ovf_d;
    logic                  valid_q, valid_d;
    logic [PRE_W-1:0]      presc_q, presc_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] sel_q, sel_d;

    logic                  conv_done;
    logic [BCD_W-1:0]      conv_bcd;
    logic                  conv_ovf;
    logic [3:0]            digit_arr [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] blank_vec;
    logic [NUM_DIGITS-1:0] sel_onehot;
    logic [6:0]            glyph;
    logic                  presc_last;

    bin2bcd_iter #(
        .BIN_WIDTH  (BIN_WIDTH),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_conv (
        .clk        (clk),
        .reset      (reset),
        .start_i    (load),
        .hex_i      (hex_mode),
        .value_i    (value),
        .busy_o     (busy),
        .done_o     (conv_done),
        .bcd_o      (conv_bcd),
        .overflow_o (conv_ovf)
    );

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        assign digit_arr[gi]  = digits_q[gi*4 +: 4];
        assign sel_onehot[gi] = (idx_q == IDX_W'(gi));
        // Digit 0 always shows; higher digits blank only if everything above is zero too.
        if (gi == 0) begin : g_lsd
            assign blank_vec[gi] = 1'b0;
        end else begin : g_upper
            assign blank_vec[gi] = blank_lz && (digits_q[BCD_W-1:4*gi] == '0);
        end
    end

    assign presc_last = (presc_q == PRE_W'(REFRESH_DIV - 1));

    always_comb begin
        digits_d = digits_q;
        ovf_d    = ovf_q;
        valid_d  = valid_q;
        if (conv_done) begin
            digits_d = conv_bcd;
            ovf_d    = conv_ovf;
            valid_d  = 1'b1;
        end

        presc_d = presc_q + PRE_W'(1);
        idx_d   = idx_q;
        if (presc_last) begin
            presc_d = '0;
            idx_d   = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end

        glyph = SEG_OFF;
        if (valid_q) begin
            if (ovf_q)                 glyph = GLYPH_DASH;
            else if (!blank_vec[idx_q]) glyph = nibble_to_glyph(digit_arr[idx_q]);
        end

        seg_d = ACTIVE_LOW ? ~glyph : glyph;
        dp_d  = ACTIVE_LOW ? ~(valid_q & dp_mask[idx_q]) : (valid_q & dp_mask[idx_q]);
        sel_d = ACTIVE_LOW ? ~sel_onehot : sel_onehot;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            digits_q <= '0;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
            presc_q  <= '0;
            idx_q    <= '0;
            seg_q    <= SEG_IDLE;
            dp_q     <= ACTIVE_LOW;
            sel_q    <= SEL_IDLE;
        end else begin
            digits_q <= digits_d;
            ovf_q    <= ovf_d;
            valid_q  <= valid_d;
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
            sel_q    <= sel_d;
        end
    end

    assign overflow  = ovf_q;
    assign seg       = seg_q;
    assign dp        = dp_q;
    assign digit_sel = sel_q;

endmodule

// File: doc/seg7_scan_display.md
Name: seg7_scan_display

Overview:
- Multi-digit seven-segment display driver for the reaction-time readout; generalises the single-digit BCD decoder.
- Accepts a binary value and converts it to BCD sequentially (iterative double-dabble), or uses the raw nibbles in hex mode.
- Drives one shared segment bus and time-multiplexes NUM_DIGITS common-anode digits.
- Adds leading-zero blanking, overflow indication, full hex glyphs and a decimal-point mask.

Parameters:
NUM_DIGITS, 4, digits driven/scanned (1..8)
BIN_WIDTH, 14, width of binary input value
REFRESH_DIV, 50000, clk cycles each digit is lit (>=2)
ACTIVE_LOW, 1, 1 = segments and digit selects active-low; 0 = active-high

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
value  input  BIN_WIDTH  binary value to display
load  input  1  single-cycle request to latch value and convert
hex_mode  input  1  sampled with load; 1 = hex nibbles, 0 = decimal
blank_lz  input  1  live; 1 = blank leading zero digits
dp_mask  input  NUM_DIGITS  live; bit i lights decimal point of digit i
busy  output  1  conversion in progress; load ignored while high
overflow  output  1  last accepted value not representable in NUM_DIGITS
digit_sel  output  NUM_DIGITS  one-hot digit enable (polarity per ACTIVE_LOW)
seg  output  7  segments {g,f,e,d,c,b,a} (polarity per ACTIVE_LOW)
dp  output  1  decimal point for currently selected digit

Behaviour:
- Reset is synchronous and clears all state: busy=0, overflow=0, scan index=0, prescaler=0, display valid=0. seg and dp read all-off (7'h7F and 1 when ACTIVE_LOW). digit_sel reads all-off.
- Accept rule: load && !busy latches value and hex_mode. A load while busy is dropped with no side effects.
- Decimal conversion:
  - busy rises the cycle after load and stays high for exactly BIN_WIDTH cycles.
  - Each cycle: add 3 to every BCD nibble >= 5, then shift left one bit, bringing in the next MSB of value.
  - overflow = 1 if any 1 is shifted out of the 4*NUM_DIGITS-bit BCD register.
- Hex conversion: busy high for exactly 1 cycle. The digits are the low 4*NUM_DIGITS bits of value. overflow = 1 if any higher bit is set.
- Commit: on the final busy cycle, the digit registers, overflow and valid=1 update together. The display never shows a partial result; the old contents stay up until commit.
- Overflow display: every digit shows a dash (g only). Blanking is ignored.
- Glyphs: 0-9 as in the team BCD table (active-low 0 = 7'b1000000). A,b,C,d,E,F are fully defined, with no don't-cares.
- Leading-zero blanking: digit i (i>0) is blanked when blank_lz=1 and digits NUM_DIGITS-1..i are all zero. Digit 0 is never blanked.
- Scan:
  - The prescaler counts 0..REFRESH_DIV-1.
  - At terminal count the scan index advances, wrapping NUM_DIGITS-1 -> 0.
  - The scan runs continuously, independent of busy.
- Output timing: seg, dp and digit_sel are registered and reflect the new index one cycle after it changes. digit_sel is the only active select, with no overlap.
- While valid=0: seg and dp stay all-off and digit_sel continues to scan.
- Reset mid-conversion aborts it; valid returns to 0 (blank display).
- Width rules: BCD register is 4*NUM_DIGITS bits. The shift counter is clog2(BIN_WIDTH+1) bits. The prescaler is clog2(REFRESH_DIV) bits.

Decomposition:
- Package seg7_pkg holds:
  - 7-bit active-high glyph constants for 0-F and dash.
  - a function mapping nibble to glyph.
  - the SEG_OFF constant.
- Polarity inversion is applied once, at the output registers.
- One sub-module: bin2bcd_iter, the sequential double-dabble engine (start, value in; busy, done, bcd, overflow out). Parameterised by BIN_WIDTH and NUM_DIGITS.

Test Plan:
- Default params, REFRESH_DIV=4; hold reset 3 cycles -> busy=0, overflow=0, seg=7'h7F, dp=1, digit_sel=4'hF.
- load value=1234, hex_mode=0 -> busy=1 for 14 cycles, then valid. Over one scan: digit_sel=4'b1110 with seg=7'b0011001 (4), then 1101/0110000 (3), 1011/0100100 (2), 0111/1111001 (1).
- value=7, blank_lz=1 -> digit0 seg=7'b1111000, digits 1-3 seg=7'h7F. With blank_lz=0, digits 1-3 show 7'b1000000.
- value=10000 decimal -> overflow=1, every digit seg=7'b0111111. Then load value=9999 -> overflow=0, all digits 7'b0010000.
- hex_mode=1, value=14'h3BEF -> busy 1 cycle. Digits 0..3 show 7'b0001110 (F), 7'b0000110 (E), 7'b0000011 (b), 7'b0110000 (3). dp_mask=4'b0100 -> dp=0 only while digit_sel=4'b1011.
- load 1234 then load 5678 at busy cycle 3 -> second load ignored, 1234 displayed. Assert reset at busy cycle 5 -> busy=0, seg=7'h7F thereafter.
